// File: rtl/tetromino_queue_pkg.sv
// ---------------------------------------------------------------------------
// tetromino_queue_pkg: piece/state types and LFSR helpers. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package tetromino_queue_pkg;

  typedef enum logic [2:0] {
    TILE_I = 3'd0,
    TILE_O = 3'd1,
    TILE_T = 3'd2,
    TILE_J = 3'd3,
    TILE_L = 3'd4,
    TILE_S = 3'd5,
    TILE_Z = 3'd6,
    BLANK  = 3'd7
  } tile_type_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    READY = 2'd2
  } queue_states_t;

  localparam int          PREVIEW_DEPTH_MAX = 6;
  // Taps 16,14,13,11 of a left-shifting Fibonacci register.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [6:0]  BAG_FULL          = 7'h7F;

  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/tetromino_queue_if.sv
// ---------------------------------------------------------------------------
// tetromino_queue_if: game-FSM <-> piece queue control and display bus. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface tetromino_queue_if #(
  parameter int PREVIEW_DEPTH = 6
);
  import tetromino_queue_pkg::*;

  logic                            game_start;
  logic                            game_end;
  logic                            new_tetromino;
  logic                            hold_req;
  tile_type_t                      active_piece;
  tile_type_t [PREVIEW_DEPTH-1:0]  preview;
  tile_type_t                      hold_piece;
  logic                            hold_avail;
  logic                            queue_ready;

  modport master (
    output game_start, game_end, new_tetromino, hold_req,
    input  active_piece, preview, hold_piece, hold_avail, queue_ready
  );

  modport slave (
    input  game_start, game_end, new_tetromino, hold_req,
    output active_piece, preview, hold_piece, hold_avail, queue_ready
  );

endinterface

`default_nettype wire

// File: rtl/tetromino_queue_bag_randomizer.sv
// ---------------------------------------------------------------------------
// bag_randomizer: free-running LFSR feeding a 7-bag draw. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module bag_randomizer
  import tetromino_queue_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       draw_en,
  input  logic       bag_clr,
  output tile_type_t piece
);

  logic [15:0] lfsr;
  logic [6:0]  mask;
  logic [2:0]  cand;
  logic [2:0]  pick;
  logic [3:0]  idx;
  logic [6:0]  remaining;

  // Scan farthest-first so the nearest set bit after cand is the last to win.
  always_comb begin
    cand = (lfsr[2:0] == 3'd7) ? 3'd0 : lfsr[2:0];
    pick = cand;
    idx  = 4'd0;
    for (int k = 6; k >= 0; k--) begin
      idx = {1'b0, cand} + 4'(k);
      if (idx >= 4'd7) idx = idx - 4'd7;
      if (mask[idx[2:0]]) pick = idx[2:0];
    end
    remaining = mask & ~(7'd1 << pick);
  end

  assign piece = tile_type_t'(pick);

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= LFSR_SEED;
      mask <= BAG_FULL;
    end else begin
      lfsr <= lfsr_next(lfsr);
      if (bag_clr) begin
        mask <= BAG_FULL;
      end else if (draw_en) begin
        mask <= (remaining == 7'd0) ? BAG_FULL : remaining;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/tetromino_queue.sv
// ---------------------------------------------------------------------------
// tetromino_queue: active piece, preview shift register and hold slot. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tetromino_queue
  import tetromino_queue_pkg::*;
#(
  parameter int          PREVIEW_DEPTH = 6,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                clk,
  input  logic                rst,
  tetromino_queue_if.slave    q
);

  localparam int SLOTS = PREVIEW_DEPTH + 1;
  localparam int CNT_W = $clog2(PREVIEW_DEPTH_MAX + 1);

  queue_states_t    state;
  tile_type_t       slot [SLOTS];
  tile_type_t       hold;
  logic             hold_avail_r;
  logic             queue_ready_r;
  logic             pop_pending;
  logic [CNT_W-1:0] fill_cnt;

  tile_type_t       drawn;
  logic             draw_en;
  logic             bag_clr;
  logic             do_pop;
  logic             do_stash;
  logic             do_swap;

  bag_randomizer #(
    .LFSR_SEED (LFSR_SEED)
  ) u_bag (
    .clk     (clk),
    .rst     (rst),
    .draw_en (draw_en),
    .bag_clr (bag_clr),
    .piece   (drawn)
  );

  // Priority: game_end > game_start > pop (new or pending) > hold.
  always_comb begin
    bag_clr  = 1'b0;
    draw_en  = 1'b0;
    do_pop   = 1'b0;
    do_stash = 1'b0;
    do_swap  = 1'b0;
    if (!q.game_end) begin
      if (q.game_start) begin
        bag_clr = 1'b1;
      end else if (state == FILL) begin
        draw_en = 1'b1;
      end else if (state == READY) begin
        if (q.new_tetromino || pop_pending) begin
          do_pop = 1'b1;
        end else if (q.hold_req && hold_avail_r) begin
          do_stash = (hold == BLANK);
          do_swap  = (hold != BLANK);
        end
        draw_en = do_pop | do_stash;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      for (int i = 0; i < SLOTS; i++) slot[i] <= BLANK;
      hold          <= BLANK;
      hold_avail_r  <= 1'b0;
      queue_ready_r <= 1'b0;
      pop_pending   <= 1'b0;
      fill_cnt      <= '0;
    end else if (q.game_end) begin
      state         <= IDLE;
      queue_ready_r <= 1'b0;
      pop_pending   <= 1'b0;
    end else if (q.game_start) begin
      state         <= FILL;
      for (int i = 0; i < SLOTS; i++) slot[i] <= BLANK;
      hold          <= BLANK;
      hold_avail_r  <= 1'b0;
      queue_ready_r <= 1'b0;
      pop_pending   <= 1'b0;
      fill_cnt      <= '0;
    end else begin
      case (state)
        FILL: begin
          slot[fill_cnt] <= drawn;
          fill_cnt       <= fill_cnt + 1'b1;
          if (q.new_tetromino) pop_pending <= 1'b1;
          if (fill_cnt == CNT_W'(SLOTS - 1)) state <= READY;
        end
        READY: begin
          queue_ready_r <= 1'b1;
          if (do_pop || do_stash) begin
            for (int i = 0; i < SLOTS - 1; i++) slot[i] <= slot[i+1];
            slot[SLOTS-1] <= drawn;
          end
          if (do_stash) hold <= slot[0];
          if (do_swap) begin
            slot[0] <= hold;
            hold    <= slot[0];
          end
          if (do_pop) begin
            hold_avail_r <= 1'b1;
            pop_pending  <= 1'b0;
          end else if (do_stash || do_swap) begin
            hold_avail_r <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign q.active_piece = slot[0];
  assign q.hold_piece   = hold;
  assign q.hold_avail   = hold_avail_r;
  assign q.queue_ready  = queue_ready_r;

  for (genvar g = 0; g < PREVIEW_DEPTH; g++) begin : g_preview
    assign q.preview[g] = slot[g+1];
  end

endmodule

`default_nettype wire

// File: tb/tb_tetromino_queue.sv
// ---------------------------------------------------------------------------
// tb_tetromino_queue: scoreboard bench for the 7-bag piece queue. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_tetromino_queue;
  import tetromino_queue_pkg::*;

  localparam int          PD   = 6;
  localparam int          NS   = PD + 1;
  localparam logic [15:0] SEED = 16'hACE1;

  logic clk = 1'b0;
  logic rst;

  tetromino_queue_if #(.PREVIEW_DEPTH(PD)) qif ();

  tetromino_queue #(
    .PREVIEW_DEPTH (PD),
    .LFSR_SEED     (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .q   (qif)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int dcnt   = 0;

  int          tag_q [$];
  logic [25:0] exp_q [$];
  string       name_q[$];

  // Reference model of the queue, stepped once per clock by the driver.
  logic [15:0] m_lfsr;
  logic [6:0]  m_mask;
  int          m_st;
  logic [2:0]  m_slot [NS];
  logic [2:0]  m_hold;
  bit          m_hav, m_qr, m_pend;
  int          m_cnt;
  logic [2:0]  draws [$];
  logic [2:0]  obs [$];

  function automatic logic [2:0] draw_of(input logic [15:0] l, input logic [6:0] m);
    int c;
    c = int'(l[2:0]);
    if (c == 7) c = 0;
    for (int k = 0; k < 7; k++)
      if (m[(c + k) % 7]) return 3'((c + k) % 7);
    return 3'd7;
  endfunction

  function automatic logic [25:0] pack_model();
    logic [25:0] v;
    v = '0;
    v[25:23] = m_slot[0];
    for (int i = 0; i < PD; i++) v[5 + 3*i +: 3] = m_slot[i+1];
    v[4:2] = m_hold;
    v[1]   = m_hav;
    v[0]   = m_qr;
    return v;
  endfunction

  task automatic mpop(input logic [2:0] d);
    for (int i = 0; i < NS - 1; i++) m_slot[i] = m_slot[i+1];
    m_slot[NS-1] = d;
  endtask

  task automatic step(input bit r, input bit gs, input bit ge, input bit nt, input bit hr);
    logic [2:0] d, t;
    bit used;
    d = draw_of(m_lfsr, m_mask);
    used = 0;
    if (r) begin
      m_st = 0; m_hold = 3'd7; m_hav = 0; m_qr = 0; m_pend = 0; m_cnt = 0;
      for (int i = 0; i < NS; i++) m_slot[i] = 3'd7;
      m_lfsr = SEED; m_mask = 7'h7F;
    end else begin
      if (ge) begin
        m_st = 0; m_qr = 0; m_pend = 0;
      end else if (gs) begin
        m_st = 1; m_hold = 3'd7; m_hav = 0; m_qr = 0; m_pend = 0; m_cnt = 0;
        for (int i = 0; i < NS; i++) m_slot[i] = 3'd7;
        m_mask = 7'h7F;
      end else if (m_st == 1) begin
        m_slot[m_cnt] = d; used = 1; m_cnt++;
        if (nt) m_pend = 1;
        if (m_cnt == NS) m_st = 2;
      end else if (m_st == 2) begin
        m_qr = 1;
        if (nt || m_pend) begin
          mpop(d); used = 1; m_hav = 1; m_pend = 0;
        end else if (hr && m_hav) begin
          if (m_hold == 3'd7) begin
            m_hold = m_slot[0]; mpop(d); used = 1;
          end else begin
            t = m_hold; m_hold = m_slot[0]; m_slot[0] = t;
          end
          m_hav = 0;
        end
      end
      if (used) begin
        m_mask = m_mask & ~(7'd1 << d);
        if (m_mask == 7'd0) m_mask = 7'h7F;
        draws.push_back(d);
      end
      m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end
  endtask

  task automatic cyc(input bit r, input bit gs, input bit ge, input bit nt, input bit hr,
                     input string nm);
    rst               = r;
    qif.game_start    = gs;
    qif.game_end      = ge;
    qif.new_tetromino = nt;
    qif.hold_req      = hr;
    step(r, gs, ge, nt, hr);
    dcnt++;
    tag_q.push_back(dcnt);
    exp_q.push_back(pack_model());
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, nm);
  endtask

  task automatic chk(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, want);
    end
  endtask

  // Monitor: compares the DUT against the scoreboard entry due this cycle.
  initial begin
    int          ncnt;
    logic [25:0] got, want;
    string       nm;
    ncnt = 0;
    forever begin
      @(negedge clk);
      ncnt++;
      if (tag_q.size() > 0 && tag_q[0] == ncnt) begin
        void'(tag_q.pop_front());
        want = exp_q.pop_front();
        nm   = name_q.pop_front();
        got  = {qif.active_piece, qif.preview, qif.hold_piece, qif.hold_avail, qif.queue_ready};
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL %s cycle %0d: got act=%0d pv=%h hold=%0d ha=%b qr=%b, expected act=%0d pv=%h hold=%0d ha=%b qr=%b",
                   nm, ncnt, got[25:23], got[22:5], got[4:2], got[1], got[0],
                   want[25:23], want[22:5], want[4:2], want[1], want[0]);
        end
      end
    end
  end

  initial begin
    logic [6:0] seen;
    logic [2:0] a, prev0, h;
    int         base, run, maxrun, sevens;
    bit         found;

    // Reset and idle
    cyc(1, 0, 0, 0, 0, "reset");
    cyc(1, 0, 0, 0, 0, "reset");
    idle(2, "idle");

    // Fill: queue_ready exactly 8 cycles after game_start
    cyc(0, 1, 0, 0, 0, "start");
    idle(7, "fill");
    chk("ready_not_yet", int'(qif.queue_ready), 0);
    idle(1, "fill_done");
    chk("ready_at_8", int'(qif.queue_ready), 1);
    seen = '0;
    obs.push_back(qif.active_piece);
    for (int i = 0; i < PD; i++) obs.push_back(qif.preview[i]);
    for (int i = 0; i < NS; i++) if (obs[i] < 3'd7) seen[obs[i]] = 1'b1;
    chk("fill_distinct", int'(seen), 127);

    // 700 pops, 3 cycles apart
    for (int p = 0; p < 700; p++) begin
      cyc(0, 0, 0, 1, 0, "pop_run");
      obs.push_back(qif.preview[PD-1]);
      idle(2, "pop_run_gap");
    end
    for (int g = 0; g < obs.size() / 7; g++) begin
      seen = '0;
      for (int i = 0; i < 7; i++) if (obs[7*g+i] < 3'd7) seen[obs[7*g+i]] = 1'b1;
      chk("bag_permutation", int'(seen), 127);
    end
    run = 1; maxrun = 1; sevens = 0;
    for (int i = 0; i < obs.size(); i++) begin
      if (obs[i] == 3'd7) sevens++;
      if (i > 0) begin
        run = (obs[i] == obs[i-1]) ? run + 1 : 1;
        if (run > maxrun) maxrun = run;
      end
    end
    chk("no_blank_drawn", sevens, 0);
    chk("max_repeat_le_2", int'(maxrun <= 2), 1);

    // Pop one cycle after game_start is deferred to the first READY cycle
    cyc(0, 1, 0, 0, 0, "restart");
    base = draws.size();
    cyc(0, 0, 0, 1, 0, "pop_in_fill");
    idle(7, "fill_pending");
    chk("pending_ready", int'(qif.queue_ready), 1);
    chk("pending_active", int'(qif.active_piece), int'(draws[base+1]));
    chk("pending_last", int'(qif.preview[PD-1]), int'(draws[base+7]));

    // Hold: pop until the active piece is T
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_slot[0] == 3'd2 && m_hav && m_hold == 3'd7) found = 1;
      else begin
        cyc(0, 0, 0, 1, 0, "seek_T");
        idle(1, "seek_T_gap");
      end
    end
    chk("found_T", int'(found), 1);
    prev0 = m_slot[1];
    cyc(0, 0, 0, 0, 1, "hold_stash");
    chk("stash_hold", int'(qif.hold_piece), 2);
    chk("stash_active", int'(qif.active_piece), int'(prev0));
    chk("stash_avail", int'(qif.hold_avail), 0);
    cyc(0, 0, 0, 0, 1, "hold_ignored");
    cyc(0, 0, 0, 1, 0, "pop_after_hold");
    a = m_slot[0];
    cyc(0, 0, 0, 0, 1, "hold_swap");
    chk("swap_active", int'(qif.active_piece), 2);
    chk("swap_hold", int'(qif.hold_piece), int'(a));

    // Simultaneous pop and hold: pop only
    h = m_hold;
    cyc(0, 0, 0, 1, 1, "pop_and_hold");
    chk("simul_hold_kept", int'(qif.hold_piece), int'(h));
    chk("simul_avail", int'(qif.hold_avail), 1);

    // game_end freezes, ignores pops, and wins over game_start
    cyc(0, 0, 1, 0, 0, "end");
    chk("end_not_ready", int'(qif.queue_ready), 0);
    cyc(0, 0, 0, 1, 0, "end_pop_ignored");
    cyc(0, 1, 1, 0, 0, "end_beats_start");
    idle(2, "idle_after_end");
    chk("still_idle", int'(qif.queue_ready), 0);
    cyc(0, 1, 0, 0, 0, "restart2");
    idle(8, "refill");
    chk("refill_hold_blank", int'(qif.hold_piece), 7);
    chk("refill_ready", int'(qif.queue_ready), 1);

    // Reset in the middle of a fill
    cyc(0, 1, 0, 0, 0, "start_then_rst");
    idle(3, "partial_fill");
    cyc(1, 0, 0, 0, 0, "rst_mid_fill");
    chk("rst_active_blank", int'(qif.active_piece), 7);
    chk("rst_preview0_blank", int'(qif.preview[0]), 7);
    idle(2, "post_rst");

    @(negedge clk);
    @(negedge clk);
    chk("scoreboard_drained", tag_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
